chunk_serial_adder: RTL and testbench

- Parametrised multi-cycle signed adder/subtractor.
- Takes two WIDTH-bit two's-complement operands and returns a sign-extended WIDTH+1-bit result that never overflows.
- Processes CHUNK bits per clock through one CHUNK-bit adder slice, trading latency for area.
- Uses valid/ready handshakes on input and output, so it can sit between pipeline stages of the datapath.

---
 rtl/chunk_serial_adder_if.sv | 46 ++++
 rtl/chunk_serial_adder.sv | 134 +++++++++++++
 tb/tb_chunk_serial_adder.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chunk_serial_adder_if.sv
// ============================================================================
//  Module   : chunk_serial_adder_if
//  Purpose  : Operand/result handshake bundle for chunk_serial_adder.
//             ovf exists only when CHUNK_SERIAL_ADDER_OVF_EN is defined.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface chunk_serial_adder_if #(
    parameter int WIDTH = 11
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out;
    logic             busy;
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, out, busy, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, out, busy, ovf
    );
`else
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, out, busy
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, out, busy
    );
`endif
endinterface

`default_nettype wire

// File: rtl/chunk_serial_adder.sv
// ============================================================================
//  Module   : chunk_serial_adder
//  Purpose  : Multi-cycle signed add/subtract, CHUNK bits per clock through a
//             single slice; optional ovf flag via CHUNK_SERIAL_ADDER_OVF_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module chunk_serial_adder #(
    parameter int WIDTH = 11,
    parameter int CHUNK = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    chunk_serial_adder_if.slave io
);

    localparam int NCHUNK = (WIDTH + CHUNK) / CHUNK;
    localparam int EW     = NCHUNK * CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q;
    logic          carry_q;
    logic [EW-1:0] a_q;
    logic [EW-1:0] b_q;
    logic [EW-1:0] r_q;

    logic          accept;
    logic          step;
    logic          last;
    logic [CHUNK:0] sum;
    logic [EW-1:0] r_next;
    logic [EW-1:0] a_ext;
    logic [EW-1:0] b_ext;

    assign a_ext = {{(EW-WIDTH){io.a[WIDTH-1]}}, io.a};
    assign b_ext = {{(EW-WIDTH){io.b[WIDTH-1]}}, io.b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (idx_q == LAST_IDX) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.busy      = (state_q != IDLE);
    assign io.out       = r_q[WIDTH:0];

    // Operands shift down so the slice always sees bit 0; results enter at the top.
    assign sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};

    if (EW == CHUNK) begin : g_one_chunk
        assign r_next = sum[CHUNK-1:0];
    end else begin : g_multi_chunk
        assign r_next = {sum[CHUNK-1:0], r_q[EW-1:CHUNK]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
        end else if (accept) begin
            idx_q   <= '0;
            carry_q <= io.sub;
            a_q     <= a_ext;
            b_q     <= io.sub ? ~b_ext : b_ext;
        end else if (step) begin
            idx_q   <= idx_q + IW'(1);
            carry_q <= sum[CHUNK];
            a_q     <= a_q >> CHUNK;
            b_q     <= b_q >> CHUNK;
            r_q     <= r_next;
        end
    end

`ifdef CHUNK_SERIAL_ADDER_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (last) begin
            ovf_q <= r_next[WIDTH] ^ r_next[WIDTH-1];
        end
    end

    assign io.ovf = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_chunk_serial_adder.sv
// ============================================================================
//  Module   : tb_chunk_serial_adder
//  Purpose  : Directed and sweep checks for chunk_serial_adder.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_chunk_serial_adder;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    chunk_serial_adder_if #(.WIDTH(11)) dif();
    chunk_serial_adder #(.WIDTH(11), .CHUNK(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (dif)
    );

    logic       sw_in_valid  [3];
    logic [7:0] sw_a         [3];
    logic [7:0] sw_b         [3];
    logic       sw_sub       [3];
    logic       sw_out_ready [3];
    logic       sw_in_ready  [3];
    logic       sw_out_valid [3];
    logic       sw_busy      [3];
    logic [8:0] sw_out       [3];
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
    logic       sw_ovf       [3];
`endif

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int CH = (g == 0) ? 9 : ((g == 1) ? 3 : 1);
        chunk_serial_adder_if #(.WIDTH(8)) sif();
        assign sif.in_valid  = sw_in_valid[g];
        assign sif.a         = sw_a[g];
        assign sif.b         = sw_b[g];
        assign sif.sub       = sw_sub[g];
        assign sif.out_ready = sw_out_ready[g];
        assign sw_in_ready[g]  = sif.in_ready;
        assign sw_out_valid[g] = sif.out_valid;
        assign sw_busy[g]      = sif.busy;
        assign sw_out[g]       = sif.out;
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
        assign sw_ovf[g]       = sif.ovf;
`endif
        chunk_serial_adder #(.WIDTH(8), .CHUNK(CH)) u_sw (
            .clk   (clk),
            .rst_n (rst_n),
            .io    (sif)
        );
    end

    // Called at #1 after an edge with the default DUT idle.
    task automatic start_op(input logic [10:0] a, input logic [10:0] b, input logic s);
        dif.a        = a;
        dif.b        = b;
        dif.sub      = s;
        dif.in_valid = 1'b1;
        @(posedge clk); #1;
        dif.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!dif.out_valid && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        #12;
        total++;
        if (dif.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", dif.in_ready); end
        total++;
        if (dif.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", dif.out_valid); end
        total++;
        if (dif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", dif.busy); end
        total++;
        if (dif.out !== 12'h000) begin bad++; $display("FAIL reset_out got=%h want=000", dif.out); end
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
        total++;
        if (dif.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", dif.ovf); end
`endif
        for (int k = 0; k < 3; k++) begin
            total++;
            if (sw_in_ready[k] !== 1'b1 || sw_out_valid[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_sweep%0d in_ready=%b out_valid=%b want 1/0", k, sw_in_ready[k], sw_out_valid[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_max;
        int cyc;
        start_op(11'd1023, 11'd1023, 1'b0);
        wait_done(cyc);
        total++;
        if (cyc !== 3) begin bad++; $display("FAIL max_latency got=%0d want=3", cyc); end
        total++;
        if (dif.out !== 12'h7FE) begin bad++; $display("FAIL max_out got=%h want=7fe", dif.out); end
        total++;
        if ({dif.out_valid, dif.busy, dif.in_ready} !== 3'b110) begin
            bad++;
            $display("FAIL max_flags got=%b want=110", {dif.out_valid, dif.busy, dif.in_ready});
        end
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
        total++;
        if (dif.ovf !== 1'b1) begin bad++; $display("FAIL max_ovf got=%b want=1", dif.ovf); end
`endif
        dif.out_ready = 1'b1;
        @(posedge clk); #1;
        dif.out_ready = 1'b0;
        total++;
        if ({dif.out_valid, dif.in_ready, dif.out} !== {2'b01, 12'h7FE}) begin
            bad++;
            $display("FAIL max_release got=%b/%b/%h want=0/1/7fe", dif.out_valid, dif.in_ready, dif.out);
        end
    endtask

    task automatic test_arith;
        logic [10:0] va [4] = '{11'h400, 11'd5, 11'h7FF, 11'd100};
        logic [10:0] vb [4] = '{11'h400, 11'd7, 11'd1,   11'h738};
        logic        vs [4] = '{1'b0,    1'b1,  1'b0,    1'b1};
        logic [11:0] ve [4] = '{12'h800, 12'hFFE, 12'h000, 12'h12C};
        logic        vo [4] = '{1'b1,    1'b0,  1'b0,    1'b0};
        int cyc;
        for (int i = 0; i < 4; i++) begin
            start_op(va[i], vb[i], vs[i]);
            wait_done(cyc);
            total++;
            if (cyc !== 3) begin bad++; $display("FAIL arith%0d_latency got=%0d want=3", i, cyc); end
            total++;
            if (dif.out !== ve[i]) begin bad++; $display("FAIL arith%0d_out got=%h want=%h", i, dif.out, ve[i]); end
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
            total++;
            if (dif.ovf !== vo[i]) begin bad++; $display("FAIL arith%0d_ovf got=%b want=%b", i, dif.ovf, vo[i]); end
`else
            if (vo[i] === 1'bx) $display("arith vector %0d has undefined ovf", i);
`endif
            dif.out_ready = 1'b1;
            @(posedge clk); #1;
            dif.out_ready = 1'b0;
            total++;
            if (dif.out_valid !== 1'b0) begin bad++; $display("FAIL arith%0d_drop got=%b want=0", i, dif.out_valid); end
        end
    endtask

    task automatic test_stall;
        int cyc;
        start_op(11'h400, 11'd1023, 1'b1);
        wait_done(cyc);
        total++;
        if (dif.out !== 12'h801) begin bad++; $display("FAIL stall_out got=%h want=801", dif.out); end
        dif.a        = 11'd3;
        dif.b        = 11'd3;
        dif.sub      = 1'b0;
        dif.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if ({dif.out_valid, dif.in_ready, dif.out} !== {2'b10, 12'h801}) begin
                bad++;
                $display("FAIL stall_hold%0d got=%b/%b/%h want=1/0/801", i, dif.out_valid, dif.in_ready, dif.out);
            end
        end
        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b1;
        @(posedge clk); #1;
        dif.out_ready = 1'b0;
        total++;
        if ({dif.out_valid, dif.in_ready, dif.out} !== {2'b01, 12'h801}) begin
            bad++;
            $display("FAIL stall_release got=%b/%b/%h want=0/1/801", dif.out_valid, dif.in_ready, dif.out);
        end
        @(posedge clk); #1;
        total++;
        if (dif.busy !== 1'b0) begin bad++; $display("FAIL stall_ignored_in got busy=%b want=0", dif.busy); end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        start_op(11'd1, 11'd2, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({dif.in_ready, dif.out_valid, dif.busy, dif.out} !== {3'b100, 12'h000}) begin
            bad++;
            $display("FAIL midreset_outputs got=%b/%b/%b/%h want=1/0/0/000",
                     dif.in_ready, dif.out_valid, dif.busy, dif.out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (dif.out_valid !== 1'b0 || dif.busy !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL midreset_no_result got=%0d active cycles want=0", seen); end
    endtask

    task automatic test_sweep(input int k, input int nch);
        logic [7:0] ra, rb;
        logic       rs;
        logic [8:0] exp;
        int         ea, eb, cyc, stall;
        for (int it = 0; it < 200; it++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rs  = 1'($urandom);
            ea  = $signed(ra);
            eb  = $signed(rb);
            exp = rs ? 9'(ea - eb) : 9'(ea + eb);
            sw_a[k]        = ra;
            sw_b[k]        = rb;
            sw_sub[k]      = rs;
            sw_in_valid[k] = 1'b1;
            @(posedge clk); #1;
            sw_in_valid[k] = 1'b0;
            sw_a[k]        = ~ra;
            cyc = 0;
            while (!sw_out_valid[k] && cyc < 40) begin
                sw_out_ready[k] = 1'($urandom);
                @(posedge clk); #1;
                cyc++;
            end
            sw_out_ready[k] = 1'b0;
            total++;
            if (cyc !== nch) begin bad++; $display("FAIL sweep%0d_latency it=%0d got=%0d want=%0d", k, it, cyc, nch); end
            stall = $urandom_range(0, 3);
            repeat (stall) begin @(posedge clk); #1; end
            total++;
            if ({sw_out_valid[k], sw_out[k]} !== {1'b1, exp}) begin
                bad++;
                $display("FAIL sweep%0d_out it=%0d a=%h b=%h sub=%b got=%b/%h want=1/%h",
                         k, it, ra, rb, rs, sw_out_valid[k], sw_out[k], exp);
            end
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
            total++;
            if (sw_ovf[k] !== (exp[8] ^ exp[7])) begin
                bad++;
                $display("FAIL sweep%0d_ovf it=%0d got=%b want=%b", k, it, sw_ovf[k], exp[8] ^ exp[7]);
            end
`endif
            sw_out_ready[k] = 1'b1;
            @(posedge clk); #1;
            sw_out_ready[k] = 1'b0;
            total++;
            if (sw_in_ready[k] !== 1'b1) begin bad++; $display("FAIL sweep%0d_idle it=%0d got=%b want=1", k, it, sw_in_ready[k]); end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        dif.in_valid  = 1'b0;
        dif.a         = '0;
        dif.b         = '0;
        dif.sub       = 1'b0;
        dif.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sw_in_valid[k]  = 1'b0;
            sw_a[k]         = '0;
            sw_b[k]         = '0;
            sw_sub[k]       = 1'b0;
            sw_out_ready[k] = 1'b0;
        end
        test_reset;
        test_add_max;
        test_arith;
        test_stall;
        test_reset_mid;
        test_sweep(0, 1);
        test_sweep(1, 3);
        test_sweep(2, 9);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
